// File: rtl/des_key_sched_ctrl.sv
// DES round-key sequencer: one C/D pair, one rotator, one PC-2, one key per handshake.
// Optional odd-parity key check enabled by defining DES_KEY_PARITY_CHECK_EN.
module des_key_sched_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [63:0] key,
  input  logic        decrypt,
  input  logic        abort,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [47:0] rk,
  output logic [3:0]  rk_idx,
  output logic        rk_last,
  output logic        busy,
  output logic        parity_err
);

  localparam int KEY_W      = 64;
  localparam int RK_W       = 48;
  localparam int NUM_ROUNDS = 16;
  localparam int HALF_W     = 28;
  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

  localparam logic [0:55][5:0] PC1_T = {
    6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
    6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
    6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
    6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
    6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
    6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
    6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
    6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
  };

  localparam logic [0:47][5:0] PC2_T = {
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state;
  logic [HALF_W-1:0] c, d;
  logic [HALF_W-1:0] nc, nd;
  logic [3:0]        n, n_sel;
  logic              mode;
  logic [RK_W-1:0]   nrk;

  function automatic logic [55:0] pc1(input logic [KEY_W-1:0] k);
    logic [55:0] r;
    logic [5:0]  b;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      b = 6'(7'd64 - {1'b0, PC1_T[i]});
      r[55-i] = k[b];
    end
    return r;
  endfunction

  function automatic logic [RK_W-1:0] pc2(input logic [55:0] cd);
    logic [RK_W-1:0] r;
    logic [5:0]      b;
    r = '0;
    for (int i = 0; i < RK_W; i++) begin
      b = 6'(6'd56 - PC2_T[i]);
      r[47-i] = cd[b];
    end
    return r;
  endfunction

  // Decrypt walks C/D backwards; K16 uses C0/D0 unrotated.
  function automatic logic [HALF_W-1:0] rot(
    input logic [HALF_W-1:0] h,
    input logic [3:0]        idx,
    input logic              dec
  );
    logic one;
    one = (idx == 4'd1) || (idx == 4'd8) || (idx == 4'd15);
    if (dec && idx == 4'd0) return h;
    if (dec && one)         return {h[0], h[27:1]};
    if (dec)                return {h[1:0], h[27:2]};
    if (one || idx == 4'd0) return {h[26:0], h[27]};
    return {h[25:0], h[27:26]};
  endfunction

  always_comb begin
    n_sel = (state == OUT) ? n + 4'd1 : n;
    nc    = rot(c, n_sel, mode);
    nd    = rot(d, n_sel, mode);
    nrk   = pc2({nc, nd});
  end

`ifdef DES_KEY_PARITY_CHECK_EN
  logic par_ok;
  always_comb begin
    par_ok = 1'b1;
    for (int i = 0; i < 8; i++) par_ok &= ^key[i*8 +: 8];
  end
`endif

  assign key_ready = (state == IDLE) && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      c          <= '0;
      d          <= '0;
      n          <= '0;
      mode       <= 1'b0;
      rk         <= '0;
      rk_valid   <= 1'b0;
      rk_idx     <= '0;
      rk_last    <= 1'b0;
      busy       <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (key_valid && key_ready) begin
`ifdef DES_KEY_PARITY_CHECK_EN
            if (!par_ok) begin
              parity_err <= 1'b1;
            end else begin
              {c, d} <= pc1(key);
              mode   <= decrypt;
              n      <= '0;
              busy   <= 1'b1;
              state  <= GEN;
            end
`else
            {c, d} <= pc1(key);
            mode   <= decrypt;
            n      <= '0;
            busy   <= 1'b1;
            state  <= GEN;
`endif
          end
        end
        GEN: begin
          if (abort) begin
            c     <= '0;
            d     <= '0;
            n     <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            c        <= nc;
            d        <= nd;
            rk       <= nrk;
            rk_valid <= 1'b1;
            rk_idx   <= n;
            rk_last  <= (n == LAST_IDX);
            state    <= OUT;
          end
        end
        OUT: begin
          if (abort || (rk_ready && n == LAST_IDX)) begin
            c        <= '0;
            d        <= '0;
            n        <= '0;
            rk_valid <= 1'b0;
            rk_idx   <= '0;
            rk_last  <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (rk_ready) begin
            n       <= n_sel;
            c       <= nc;
            d       <= nd;
            rk      <= nrk;
            rk_idx  <= n_sel;
            rk_last <= (n_sel == LAST_IDX);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Self-checking bench for des_key_sched_ctrl against a whole-schedule DES key model.
// Define DES_KEY_PARITY_CHECK_EN for both RTL and bench to exercise the parity check.
module tb_des_key_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic        key_ready;
  logic [63:0] key;
  logic        decrypt;
  logic        abort;
  logic        rk_valid;
  logic        rk_ready;
  logic [47:0] rk;
  logic [3:0]  rk_idx;
  logic        rk_last;
  logic        busy;
  logic        parity_err;

  des_key_sched_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key        (key),
    .decrypt    (decrypt),
    .abort      (abort),
    .rk_valid   (rk_valid),
    .rk_ready   (rk_ready),
    .rk         (rk),
    .rk_idx     (rk_idx),
    .rk_last    (rk_last),
    .busy       (busy),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int n_asrt = 0;
  int n_fail = 0;

  int pc1_t[56] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  int pc2_t[48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
    23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  int shifts[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic [47:0] exp_rk[16];
  logic [47:0] seq[16];
  logic [47:0] enc_seq[16];

  localparam logic [63:0] KEY_REF = 64'h133457799BBCDFF1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Textbook schedule: Ki uses C0/D0 rotated by the cumulative shift total.
  task automatic model(input logic [63:0] k, input bit dec);
    logic [55:0] cd;
    logic [27:0] c0, d0, cr, dr;
    logic [55:0] cd2;
    logic [47:0] kk;
    logic [47:0] keys[16];
    int tot;
    for (int i = 0; i < 56; i++) cd[55-i] = k[64-pc1_t[i]];
    c0 = cd[55:28];
    d0 = cd[27:0];
    tot = 0;
    for (int r = 0; r < 16; r++) begin
      tot += shifts[r];
      cr = (c0 << tot) | (c0 >> (28 - tot));
      dr = (d0 << tot) | (d0 >> (28 - tot));
      cd2 = {cr, dr};
      for (int j = 0; j < 48; j++) kk[47-j] = cd2[56-pc2_t[j]];
      keys[r] = kk;
    end
    for (int i = 0; i < 16; i++) exp_rk[i] = dec ? keys[15-i] : keys[i];
  endtask

  // Offers a key and consumes round keys; returns early when got == stop_at.
  task automatic run_sched(input logic [63:0] k, input bit dec,
                           input int stall, input int stop_at,
                           output int cyc);
    int w;
    int got;
    bit rr;
    model(k, dec);
    w = 0;
    while (!key_ready && w < 20) begin
      tick();
      w++;
    end
    chk("key_ready_idle", key_ready, 1);
    key_valid = 1'b1;
    key = k;
    decrypt = dec;
    tick();
    key_valid = 1'b0;
    key = $urandom();
    decrypt = $urandom_range(1);
    chk("busy_gen", busy, 1);
    chk("valid_gen", rk_valid, 0);
    chk("parity_ok", parity_err, 0);
    tick();
    chk("valid_t2", rk_valid, 1);
    got = 0;
    cyc = 0;
    while (got < 16 && cyc < 400) begin
      if (got == stop_at) return;
      chk("valid_hold", rk_valid, 1);
      chk("rk", rk, exp_rk[got]);
      chk("rk_idx", rk_idx, got);
      chk("rk_last", rk_last, got == 15);
      seq[got] = rk;
      rr = $urandom_range(99) >= stall;
      rk_ready = rr;
      tick();
      if (rr) got++;
      cyc++;
    end
    rk_ready = 1'b0;
    chk("delivered", got, 16);
    chk("valid_end", rk_valid, 0);
    chk("busy_end", busy, 0);
    chk("key_ready_end", key_ready, 1);
    chk("last_end", rk_last, 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_valid", rk_valid, 0);
    chk("rst_rk", rk, 0);
    chk("rst_idx", rk_idx, 0);
    chk("rst_last", rk_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_perr", parity_err, 0);
  endtask

  initial begin
    int cyc;
    logic [63:0] rk_key;
    rst_n = 1'b0;
    key_valid = 1'b0;
    key = '0;
    decrypt = 1'b0;
    abort = 1'b0;
    rk_ready = 1'b0;
    #3;
    chk_reset_vals();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("key_ready_rst", key_ready, 1);

    // Known-answer encrypt order at full rate
    run_sched(KEY_REF, 1'b0, 0, -1, cyc);
    chk("enc_cycles", cyc, 16);
    chk("model_k1", exp_rk[0], 48'h1B02EFFC7072);
    chk("model_k16", exp_rk[15], 48'hCB3D8B0E17F5);
    chk("dut_k1", seq[0], 48'h1B02EFFC7072);
    chk("dut_k16", seq[15], 48'hCB3D8B0E17F5);
    enc_seq = seq;

    // Decrypt order is the exact reverse
    run_sched(KEY_REF, 1'b1, 0, -1, cyc);
    chk("dec_cycles", cyc, 16);
    chk("dec_first", seq[0], 48'hCB3D8B0E17F5);
    chk("dec_last", seq[15], 48'h1B02EFFC7072);
    for (int i = 0; i < 16; i++) chk("dec_reverse", seq[i], enc_seq[15-i]);

    // Random stalls
    run_sched(KEY_REF, 1'b0, 40, -1, cyc);

    // Abort at idx 5
    run_sched(KEY_REF, 1'b0, 0, 5, cyc);
    chk("abort_at_idx", rk_idx, 5);
    abort = 1'b1;
    rk_ready = 1'b1;
    tick();
    chk("abort_valid", rk_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_kready", key_ready, 0);
    rk_ready = 1'b0;
    key_valid = 1'b1;
    key = KEY_REF;
    tick();
    chk("abort_no_accept", busy, 0);
    key_valid = 1'b0;
    abort = 1'b0;
    tick();
    run_sched(KEY_REF, 1'b0, 0, -1, cyc);
    chk("post_abort_k1", seq[0], 48'h1B02EFFC7072);

    // Async reset at idx 9
    run_sched(KEY_REF, 1'b1, 20, 9, cyc);
    chk("reset_at_idx", rk_idx, 9);
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    tick();
    rst_n = 1'b1;
    rk_ready = 1'b0;
    tick();
    run_sched(KEY_REF, 1'b0, 0, -1, cyc);
    chk("post_reset_cycles", cyc, 16);

`ifdef DES_KEY_PARITY_CHECK_EN
    key_valid = 1'b1;
    key = 64'h0;
    tick();
    key_valid = 1'b0;
    chk("perr_pulse", parity_err, 1);
    chk("perr_busy", busy, 0);
    chk("perr_kready", key_ready, 1);
    tick();
    chk("perr_clear", parity_err, 0);
    chk("perr_no_valid", rk_valid, 0);
    tick();
    chk("perr_no_valid2", rk_valid, 0);
    run_sched(KEY_REF, 1'b0, 0, -1, cyc);
`else
    run_sched(64'h0, 1'b0, 10, -1, cyc);
    chk("zero_key_k1", seq[0], 48'h0);
    chk("no_perr", parity_err, 0);
`endif

    // Random keys with odd byte parity, random mode and stalls
    for (int t = 0; t < 6; t++) begin
      rk_key = {$urandom(), $urandom()};
      for (int b = 0; b < 8; b++)
        if (^rk_key[b*8 +: 8] == 1'b0) rk_key[b*8] = ~rk_key[b*8];
      run_sched(rk_key, 1'($urandom_range(1)), 30, -1, cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
